mul3_accumulator: RTL and testbench

// Downstream consumer of the multiply-by-3 stage: accepts its 4-bit products (0,3,6,9) over a

---
 rtl/mul3_accumulator.sv | 117 +++++++++++
 tb/tb_mul3_accumulator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul3_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mul3_accumulator
// Description : Collects N_SAMPLES multiply-by-3 products over a valid/ready
//               handshake into a saturating accumulator. Sticky flags record
//               saturation and any product outside {0,3,6,9}. The final sum is
//               held with out_valid until the consumer acknowledges it.
// Revision    : 1.0 - initial release
// ============================================================================
module mul3_accumulator #(
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic             in_ready,
    input  logic             out_ack,
    output logic [ACC_W-1:0] sum,
    output logic [CNT_W-1:0] count,
    output logic             out_valid,
    output logic             sat,
    output logic             err
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] c_N_SAMPLES = CNT_W'(N_SAMPLES);
    localparam logic [ACC_W-1:0] c_SUM_MAX   = {ACC_W{1'b1}};

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_sum;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic             r_err;

    logic             w_transfer;
    logic             w_legal;
    logic [ACC_W:0]   w_tmp;
    logic [CNT_W-1:0] w_count_next;

    // Handshake, legality check and the widened sum used for overflow detection
    always_comb begin
        w_transfer   = in_valid && (r_state == c_ST_ACCUM);
        w_legal      = (in_data == 4'd0) || (in_data == 4'd3) ||
                       (in_data == 4'd6) || (in_data == 4'd9);
        w_tmp        = {1'b0, r_sum} + {{(ACC_W-3){1'b0}}, in_data};
        w_count_next = r_count + 1'b1;
    end

    // Run control and accumulation; outputs hold through DONE and IDLE until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_sum   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_sum   <= '0;
                        r_count <= '0;
                        r_sat   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= c_ST_ACCUM;
                    end
                end
                c_ST_ACCUM: begin
                    if (w_transfer) begin
                        r_count <= w_count_next;
                        // Carry out of the widened sum means the result exceeds the register range
                        if (w_tmp[ACC_W]) begin
                            r_sum <= c_SUM_MAX;
                            r_sat <= 1'b1;
                        end else begin
                            r_sum <= w_tmp[ACC_W-1:0];
                        end
                        if (!w_legal) begin
                            r_err <= 1'b1;
                        end
                        if (w_count_next == c_N_SAMPLES) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    // out_ack wins over a simultaneous start; the start is dropped
                    if (out_ack) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Output mapping
    always_comb begin
        in_ready  = (r_state == c_ST_ACCUM);
        out_valid = (r_state == c_ST_DONE);
        sum       = r_sum;
        count     = r_count;
        sat       = r_sat;
        err       = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_mul3_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul3_accumulator
// Description : Bench for mul3_accumulator. Two instances (8-bit and 4-bit
//               accumulators) share one stimulus stream and are compared every
//               cycle against a run-level reference model, plus a table of
//               directed runs and hand-written protocol sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul3_accumulator;

    localparam int c_N = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ack;

    logic       a_in_ready, a_out_valid, a_sat, a_err;
    logic [7:0] a_sum;
    logic [2:0] a_count;
    logic       b_in_ready, b_out_valid, b_sat, b_err;
    logic [3:0] b_sum;
    logic [2:0] b_count;

    mul3_accumulator #(.ACC_W(8), .N_SAMPLES(c_N), .CNT_W(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(a_in_ready), .out_ack(out_ack),
        .sum(a_sum), .count(a_count), .out_valid(a_out_valid),
        .sat(a_sat), .err(a_err)
    );

    mul3_accumulator #(.ACC_W(4), .N_SAMPLES(c_N), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(b_in_ready), .out_ack(out_ack),
        .sum(b_sum), .count(b_count), .out_valid(b_out_valid),
        .sat(b_sat), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: run phase, true (unbounded) total, accepted count, any-illegal flag
    typedef enum int {PH_IDLE, PH_ACCUM, PH_DONE} phase_t;
    phase_t m_phase = PH_IDLE;
    int     m_total = 0;
    int     m_cnt   = 0;
    bit     m_err   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit is_legal(input int d);
        return (d == 0) || (d == 3) || (d == 6) || (d == 9);
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_total = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    // Apply the rules of one rising edge using the inputs currently driven
    task automatic model_edge();
        case (m_phase)
            PH_IDLE: if (start) begin
                m_total = 0; m_cnt = 0; m_err = 1'b0; m_phase = PH_ACCUM;
            end
            PH_ACCUM: if (in_valid) begin
                m_total += int'(in_data);
                m_cnt++;
                if (!is_legal(int'(in_data))) m_err = 1'b1;
                if (m_cnt == c_N) m_phase = PH_DONE;
            end
            PH_DONE: if (out_ack) m_phase = PH_IDLE;
            default: m_phase = PH_IDLE;
        endcase
    endtask

    // Saturating sums of non-negative values equal the clipped true total
    task automatic check_all(input string tag);
        int e8, e4;
        e8 = (m_total > 255) ? 255 : m_total;
        e4 = (m_total > 15) ? 15 : m_total;
        chk({tag, " a.sum"},       int'(a_sum),       e8);
        chk({tag, " a.count"},     int'(a_count),     m_cnt);
        chk({tag, " a.in_ready"},  int'(a_in_ready),  int'(m_phase == PH_ACCUM));
        chk({tag, " a.out_valid"}, int'(a_out_valid), int'(m_phase == PH_DONE));
        chk({tag, " a.sat"},       int'(a_sat),       int'(m_total > 255));
        chk({tag, " a.err"},       int'(a_err),       int'(m_err));
        chk({tag, " b.sum"},       int'(b_sum),       e4);
        chk({tag, " b.count"},     int'(b_count),     m_cnt);
        chk({tag, " b.in_ready"},  int'(b_in_ready),  int'(m_phase == PH_ACCUM));
        chk({tag, " b.out_valid"}, int'(b_out_valid), int'(m_phase == PH_DONE));
        chk({tag, " b.sat"},       int'(b_sat),       int'(m_total > 15));
        chk({tag, " b.err"},       int'(b_err),       int'(m_err));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        start = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ack = 1'b0;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1; tick(tag); start = 1'b0;
    endtask

    task automatic feed(input string tag, input logic v, input logic [3:0] d);
        in_valid = v; in_data = d; tick(tag); in_valid = 1'b0;
    endtask

    task automatic do_ack(input string tag);
        out_ack = 1'b1; tick(tag); out_ack = 1'b0;
    endtask

    // Directed runs: four back-to-back products and the known final results
    typedef struct {
        logic [3:0] d0, d1, d2, d3;
        int         sum8;
        int         sum4;
        bit         sat4;
        bit         err;
    } run_vec_t;

    run_vec_t vecs[6];

    initial begin
        vecs[0] = '{4'd0,  4'd3,  4'd6,  4'd9,  18, 15, 1'b1, 1'b0};
        vecs[1] = '{4'd3,  4'd5,  4'd6,  4'd0,  14, 14, 1'b0, 1'b1};
        vecs[2] = '{4'd9,  4'd9,  4'd3,  4'd0,  21, 15, 1'b1, 1'b0};
        vecs[3] = '{4'd0,  4'd0,  4'd0,  4'd0,   0,  0, 1'b0, 1'b0};
        vecs[4] = '{4'd3,  4'd3,  4'd3,  4'd6,  15, 15, 1'b0, 1'b0};
        vecs[5] = '{4'd15, 4'd15, 4'd15, 4'd15, 60, 15, 1'b1, 1'b1};

        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        #4;

        // Table-driven runs
        for (int i = 0; i < 6; i++) begin
            do_start("tbl start");
            feed("tbl", 1'b1, vecs[i].d0);
            feed("tbl", 1'b1, vecs[i].d1);
            feed("tbl", 1'b1, vecs[i].d2);
            feed("tbl", 1'b1, vecs[i].d3);
            chk("tbl out_valid", int'(a_out_valid), 1);
            chk("tbl sum8",      int'(a_sum),       vecs[i].sum8);
            chk("tbl sum4",      int'(b_sum),       vecs[i].sum4);
            chk("tbl sat4",      int'(b_sat),       int'(vecs[i].sat4));
            chk("tbl err",       int'(a_err),       int'(vecs[i].err));
            chk("tbl count",     int'(a_count),     4);
            do_ack("tbl ack");
        end

        // Gaps: 3,_,_,6,_,9,3 -> 21, out_valid one cycle after the fourth accept
        do_start("gap start");
        feed("gap", 1'b1, 4'd3);
        feed("gap", 1'b0, 4'd7);
        feed("gap", 1'b0, 4'd7);
        feed("gap", 1'b1, 4'd6);
        feed("gap", 1'b0, 4'd1);
        feed("gap", 1'b1, 4'd9);
        chk("gap not done yet", int'(a_out_valid), 0);
        feed("gap", 1'b1, 4'd3);
        chk("gap out_valid", int'(a_out_valid), 1);
        chk("gap sum", int'(a_sum), 21);
        chk("gap in_ready", int'(a_in_ready), 0);
        do_ack("gap ack");

        // Illegal input raises err from the cycle after it is accepted
        do_start("ill start");
        feed("ill", 1'b1, 4'd3);
        chk("ill err before", int'(a_err), 0);
        feed("ill", 1'b1, 4'd5);
        chk("ill err after", int'(a_err), 1);
        feed("ill", 1'b1, 4'd6);
        feed("ill", 1'b1, 4'd0);
        do_ack("ill ack");
        chk("ill flags kept after ack", int'(a_err), 1);
        do_start("clear start");
        chk("clear err", int'(a_err), 0);
        chk("clear sum", int'(a_sum), 0);

        // Asynchronous reset in the middle of a run
        feed("rst", 1'b1, 4'd9);
        feed("rst", 1'b1, 4'd9);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst async sum",      int'(a_sum),      0);
        chk("rst async count",    int'(a_count),    0);
        chk("rst async in_ready", int'(a_in_ready), 0);
        chk("rst async b.sat",    int'(b_sat),      0);
        #3;
        rst_n = 1'b1;
        tick("rst idle");
        do_start("rst restart");
        feed("rst run", 1'b1, 4'd3);
        feed("rst run", 1'b1, 4'd3);
        feed("rst run", 1'b1, 4'd3);
        feed("rst run", 1'b1, 4'd3);
        chk("rst run sum", int'(a_sum), 12);

        // Protocol: start/ack outside their states are ignored
        out_ack = 1'b1; tick("proto ack in done"); out_ack = 1'b0;
        do_start("proto start");
        start = 1'b1; out_ack = 1'b1;
        feed("proto accum start+ack", 1'b1, 4'd6);
        feed("proto accum start+ack", 1'b1, 4'd6);
        feed("proto accum start+ack", 1'b1, 4'd0);
        feed("proto accum start+ack", 1'b1, 4'd3);
        start = 1'b0; out_ack = 1'b0;
        chk("proto count", int'(a_count), 4);
        start = 1'b1;
        tick("proto done start");
        tick("proto done start");
        chk("proto out_valid held", int'(a_out_valid), 1);
        out_ack = 1'b1;
        tick("proto done start+ack");
        chk("proto out_valid drop", int'(a_out_valid), 0);
        start = 1'b0; out_ack = 1'b0;
        tick("proto idle hold");
        chk("proto no relaunch", int'(a_in_ready), 0);
        chk("proto sum held idle", int'(a_sum), 15);

        // Randomised runs with random gaps, data and ack delays
        for (int r = 0; r < 25; r++) begin
            int guard;
            do_start("rnd start");
            guard = 0;
            while (m_phase == PH_ACCUM && guard < 100) begin
                logic [3:0] d;
                if ($urandom_range(0, 3) == 0) d = 4'($urandom_range(0, 15));
                else d = 4'(3 * $urandom_range(0, 3));
                start   = ($urandom_range(0, 7) == 0);
                out_ack = ($urandom_range(0, 7) == 0);
                feed("rnd accum", ($urandom_range(0, 9) < 7), d);
                guard++;
            end
            start = 1'b0; out_ack = 1'b0;
            chk("rnd run completes", int'(m_phase == PH_DONE), 1);
            repeat ($urandom_range(0, 3)) tick("rnd wait");
            do_ack("rnd ack");
            repeat ($urandom_range(0, 2)) tick("rnd idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
